dlx_mem_slave: RTL and testbench
================================

Name: dlx_mem_slave

Overview:
- Memory-side bus responder for the DLX multicycle CONTROL block. It consumes the CONTROL bus strobes AS_N and WR_N and produces the ACK_N handshake that the control state machine waits on.
- Contains a word-addressed synchronous RAM and serves fetch, load and store cycles with a configurable number of wait states.
- Also provides a loader port, used by the I/O/monitor logic to preload programs while the bus is idle.

Parameters:
- ADDR_W, 8: word address width. Depth is 2**ADDR_W.
- DATA_W, 32: data word width.
- WAIT_STATES, 2: extra cycles between request capture and ACK. Legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- AS_N  in  1  address strobe from CONTROL, active low.
- WR_N  in  1  0 = write, 1 = read; sampled with AS_N.
- ADDR  in  ADDR_W  word address (MAR contents).
- DI  in  DATA_W  write data (MDR contents).
- DO  out  DATA_W  read data to MDR/IR.
- ACK_N  out  1  transfer acknowledge, active low, registered.
- ld_we  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  DATA_W  loader data.
- ld_rdy  out  1  loader write will be accepted this cycle.
- mem_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: ACK_N=1, DO=0, state=IDLE, wait counter=0, latched request cleared. RAM contents are not cleared.
- States: IDLE, WAIT, ACK, RECOVER.
- IDLE:
  - If AS_N=0 at edge k: latch ADDR, WR_N and DI.
  - If WAIT_STATES=0, go to ACK. Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Decrement cnt each edge.
  - When cnt=0, go to ACK.
  - AS_N/ADDR/WR_N/DI changes during WAIT are ignored; latched values are used.
- Entry to ACK, edge k+1+WAIT_STATES:
  - ACK_N goes to 0 for exactly one cycle.
  - Read: DO <= mem[latched addr] on the same edge. DO holds until the next read ACK.
  - Write: mem[latched addr] <= latched DI on the same edge. DO is unchanged.
- ACK: next edge always goes to RECOVER, with ACK_N back to 1.
- RECOVER:
  - Stay until AS_N is sampled 1, then go to IDLE.
  - A master holding AS_N low through and after ACK must never receive a second ACK.
  - Minimum spacing between two ACKs is WAIT_STATES+3 cycles.
- Read latency, strobe sampled to ACK_N low: 1+WAIT_STATES cycles. Data is valid in the ACK_N=0 cycle.
- Addressing:
  - ADDR is a word address, taken modulo 2**ADDR_W; there are no out-of-range errors.
  - ADDR=all-ones followed by ADDR=0 is a normal wrap.
- Loader port:
  - ld_rdy = (state==IDLE) && AS_N.
  - When ld_we && ld_rdy: mem[ld_addr] <= ld_data at the edge.
  - ld_we while ld_rdy=0 is dropped, not queued.
  - If ld_we and AS_N=0 occur together in IDLE, the bus request wins and the loader write is dropped.
- mem_busy = (state!=IDLE), from registered state.
- Reset mid-operation (any state):
  - Return to IDLE with ACK_N=1.
  - A pending write latched in WAIT is discarded, so the RAM is not modified.
  - A read in progress produces no ACK.
- WR_N and ADDR are don't-care when AS_N=1 in IDLE.

Test Plan:
- Loader writes 0x00000020 to addr 3, then 0x8C010004 to addr 4. Bus read addr 4 with AS_N low at edge k, WAIT_STATES=2 → ACK_N=0 only in the cycle after edge k+3, DO=0x8C010004.
- Bus write addr 7 with DI=0xCAFEF00D, then read addr 7 → DO=0xCAFEF00D. The write's ACK falls exactly 3 edges after the strobe is sampled.
- AS_N held low continuously for 20 cycles → exactly one ACK_N pulse, one cycle wide. Releasing AS_N for 1 cycle and reasserting it gives a second ACK 3 cycles later.
- Assert reset in the 2nd WAIT cycle of a write to addr 5, which holds 0x11111111 → no ACK; addr 5 still reads 0x11111111; ACK_N=1 and mem_busy=0 the cycle after reset.
- ld_we=1 coinciding with AS_N=0 in IDLE (ld_addr=9, ld_data=0xAAAA5555) → ld_rdy=0, the loader write is dropped, and addr 9 keeps its old value. Also, ld_we during WAIT is dropped.
- Instance with WAIT_STATES=0, ADDR_W=4:
  - Read addr 15, then addr 0 → each ACK falls 1 edge after the strobe is sampled.
  - Back-to-back ACK spacing is 3 cycles.
  - Reads of addr 15 and addr 0 return the values preloaded at 15 and 0, with no wrap aliasing errors.

Source files
------------

// File: rtl/dlx_mem_slave.sv
// dlx_mem_slave: word-addressed RAM responder for the DLX CONTROL bus (AS_N/WR_N -> ACK_N) with wait states and a loader port
// Ports: clk/reset (sync, active high); AS_N/WR_N/ADDR/DI bus request in; DO/ACK_N bus response out;
//        ld_we/ld_addr/ld_data loader write in, ld_rdy loader accept out; mem_busy high outside IDLE.
module dlx_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AS_N,
    input  logic              WR_N,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] DO,
    output logic              ACK_N,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_rdy,
    output logic              mem_busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RECOVER} state_t;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_n;
    logic [DATA_W-1:0] r_di;
    logic [DATA_W-1:0] r_do;
    logic              r_ack_n;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              w_req;
    logic              w_xfer;
    logic              w_ld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr_n  <= 1'b1;
            r_di    <= '0;
        end else begin
            r_state <= w_next;
            if (w_req) begin
                r_addr <= ADDR;
                r_wr_n <= WR_N;
                r_di   <= DI;
                r_cnt  <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = AS_N ? S_IDLE : ((WAIT_STATES == 0) ? S_ACK : S_WAIT);
            S_WAIT:    w_next = (r_cnt == 4'd0) ? S_ACK : S_WAIT;
            S_ACK:     w_next = S_RECOVER;
            default:   w_next = AS_N ? S_IDLE : S_RECOVER;
        endcase
    end

    // The transfer happens on the edge that leaves ACK, so ACK_N is low
    // in the first RECOVER cycle; RECOVER then blocks repeat requests
    // until the master releases AS_N.
    always_comb begin
        w_req  = (r_state == S_IDLE) && !AS_N;
        w_xfer = (r_state == S_ACK);
        w_ld   = ld_we && (r_state == S_IDLE) && AS_N;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_n <= 1'b1;
            r_do    <= '0;
        end else begin
            r_ack_n <= !w_xfer;
            if (w_xfer && r_wr_n) r_do <= r_mem[r_addr];
        end
    end

    // No reset on the array; a reset during ACK must still cancel the write.
    always_ff @(posedge clk) begin
        if (w_xfer && !r_wr_n && !reset) r_mem[r_addr] <= r_di;
        else if (w_ld) r_mem[ld_addr] <= ld_data;
    end

    assign DO       = r_do;
    assign ACK_N    = r_ack_n;
    assign ld_rdy   = (r_state == S_IDLE) && AS_N;
    assign mem_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_dlx_mem_slave.sv
// tb_dlx_mem_slave: directed bench for dlx_mem_slave (WAIT_STATES=2/ADDR_W=8 and WAIT_STATES=0/ADDR_W=4 instances)
module tb_dlx_mem_slave;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    int lat, n, t1, t2;
    logic [31:0] q;

    logic a_as_n = 1, a_wr_n = 1, a_ld_we = 0;
    logic [7:0] a_addr = 0, a_ld_addr = 0;
    logic [31:0] a_di = 0, a_ld_data = 0, a_do;
    logic a_ack_n, a_ld_rdy, a_busy;

    logic b_as_n = 1, b_wr_n = 1, b_ld_we = 0;
    logic [3:0] b_addr = 0, b_ld_addr = 0;
    logic [31:0] b_di = 0, b_ld_data = 0, b_do;
    logic b_ack_n, b_ld_rdy, b_busy;

    dlx_mem_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) u_a (
        .clk(clk), .reset(reset), .AS_N(a_as_n), .WR_N(a_wr_n), .ADDR(a_addr), .DI(a_di),
        .DO(a_do), .ACK_N(a_ack_n), .ld_we(a_ld_we), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
        .ld_rdy(a_ld_rdy), .mem_busy(a_busy));

    dlx_mem_slave #(.ADDR_W(4), .DATA_W(32), .WAIT_STATES(0)) u_b (
        .clk(clk), .reset(reset), .AS_N(b_as_n), .WR_N(b_wr_n), .ADDR(b_addr), .DI(b_di),
        .DO(b_do), .ACK_N(b_ack_n), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
        .ld_rdy(b_ld_rdy), .mem_busy(b_busy));

    // Called just after a negedge; returns just after a negedge.
    task automatic load(input bit s, input logic [7:0] a, input logic [31:0] d);
        if (s) begin b_ld_we = 1; b_ld_addr = a[3:0]; b_ld_data = d; end
        else begin a_ld_we = 1; a_ld_addr = a; a_ld_data = d; end
        @(negedge clk);
        a_ld_we = 0;
        b_ld_we = 0;
    endtask

    // lat = number of edges from strobe sample to ACK_N low, -1 if none within bound.
    task automatic xfer(input bit s, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        output int l, output logic [31:0] r);
        if (s) begin b_as_n = 0; b_wr_n = ~wr; b_addr = a[3:0]; b_di = d; end
        else begin a_as_n = 0; a_wr_n = ~wr; a_addr = a; a_di = d; end
        l = -1;
        r = '0;
        for (int i = 0; i < 20 && l < 0; i++) begin
            @(negedge clk);
            if ((s ? b_ack_n : a_ack_n) === 1'b0) begin l = i; r = s ? b_do : a_do; end
        end
        a_as_n = 1;
        b_as_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(negedge clk);
        vectors++; if (a_ack_n !== 1'b1) begin miscompares++; $display("FAIL rst_ack_a: got %b expected 1", a_ack_n); end
        vectors++; if (a_do !== 32'h0) begin miscompares++; $display("FAIL rst_do_a: got %h expected 00000000", a_do); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy_a: got %b expected 0", a_busy); end
        vectors++; if (a_ld_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_ldrdy_a: got %b expected 1", a_ld_rdy); end
        vectors++; if (b_ack_n !== 1'b1 || b_do !== 32'h0) begin miscompares++; $display("FAIL rst_b: got ack=%b do=%h expected 1/00000000", b_ack_n, b_do); end
        reset = 0;
        @(negedge clk);
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy: got %b expected 0", a_busy); end
    endtask

    task automatic test_loader_read;
        load(0, 8'd3, 32'h00000020);
        load(0, 8'd4, 32'h8C010004);
        xfer(0, 0, 8'd4, 32'h0, lat, q);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd4_lat: got %0d expected 3", lat); end
        vectors++; if (q !== 32'h8C010004) begin miscompares++; $display("FAIL rd4_data: got %h expected 8c010004", q); end
        xfer(0, 0, 8'd3, 32'h0, lat, q);
        vectors++; if (q !== 32'h00000020) begin miscompares++; $display("FAIL rd3_data: got %h expected 00000020", q); end
    endtask

    task automatic test_write_read;
        xfer(0, 1, 8'd7, 32'hCAFEF00D, lat, q);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr7_lat: got %0d expected 3", lat); end
        vectors++; if (q !== 32'h00000020) begin miscompares++; $display("FAIL wr7_do_held: got %h expected 00000020", q); end
        xfer(0, 0, 8'd7, 32'h0, lat, q);
        vectors++; if (q !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rd7_data: got %h expected cafef00d", q); end
    endtask

    task automatic test_hold;
        a_as_n = 0; a_wr_n = 1; a_addr = 8'd4;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_ack_n === 1'b0) n++;
        end
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL hold_ack_cycles: got %0d expected 1", n); end
        vectors++; if (a_do !== 32'h8C010004) begin miscompares++; $display("FAIL hold_data: got %h expected 8c010004", a_do); end
        a_as_n = 1;
        @(negedge clk);
        xfer(0, 0, 8'd3, 32'h0, lat, q);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rearm_lat: got %0d expected 3", lat); end
        vectors++; if (q !== 32'h00000020) begin miscompares++; $display("FAIL rearm_data: got %h expected 00000020", q); end
    endtask

    task automatic test_reset_mid;
        load(0, 8'd5, 32'h11111111);
        a_as_n = 0; a_wr_n = 0; a_addr = 8'd5; a_di = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL wait_busy: got %b expected 1", a_busy); end
        a_as_n = 1;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        vectors++; if (a_ack_n !== 1'b1) begin miscompares++; $display("FAIL midrst_ack: got %b expected 1", a_ack_n); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", a_busy); end
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack_n === 1'b0) n++;
        end
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL midrst_noack: got %0d acks expected 0", n); end
        xfer(0, 0, 8'd5, 32'h0, lat, q);
        vectors++; if (q !== 32'h11111111) begin miscompares++; $display("FAIL midrst_mem: got %h expected 11111111", q); end
    endtask

    task automatic test_loader_drop;
        load(0, 8'd9, 32'h00000099);
        a_as_n = 0; a_wr_n = 1; a_addr = 8'd9;
        a_ld_we = 1; a_ld_addr = 8'd9; a_ld_data = 32'hAAAA5555;
        #1;
        vectors++; if (a_ld_rdy !== 1'b0) begin miscompares++; $display("FAIL ld_rdy_req: got %b expected 0", a_ld_rdy); end
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a_as_n = 1;
                #1;
                vectors++; if (a_ld_rdy !== 1'b0) begin miscompares++; $display("FAIL ld_rdy_wait: got %b expected 0", a_ld_rdy); end
            end
            if (i == 1) a_ld_we = 0;
            if (a_ack_n === 1'b0) begin lat = i; q = a_do; end
        end
        a_ld_we = 0;
        vectors++; if (lat !== 3 || q !== 32'h00000099) begin miscompares++; $display("FAIL ld_drop_read: got lat=%0d data=%h expected 3/00000099", lat, q); end
        @(negedge clk);
        vectors++; if (a_ld_rdy !== 1'b1) begin miscompares++; $display("FAIL ld_rdy_idle: got %b expected 1", a_ld_rdy); end
        xfer(0, 0, 8'd9, 32'h0, lat, q);
        vectors++; if (q !== 32'h00000099) begin miscompares++; $display("FAIL ld_drop_mem: got %h expected 00000099", q); end
    endtask

    task automatic test_wrap;
        load(0, 8'd255, 32'hFFEE0001);
        load(0, 8'd0, 32'h00010203);
        xfer(0, 0, 8'd255, 32'h0, lat, q);
        vectors++; if (q !== 32'hFFEE0001) begin miscompares++; $display("FAIL rd255: got %h expected ffee0001", q); end
        xfer(0, 0, 8'd0, 32'h0, lat, q);
        vectors++; if (q !== 32'h00010203) begin miscompares++; $display("FAIL rd0: got %h expected 00010203", q); end
    endtask

    task automatic test_ws0;
        load(1, 8'd15, 32'hF0F0F0F0);
        load(1, 8'd0, 32'h0A0A0A0A);
        xfer(1, 0, 8'd15, 32'h0, lat, q);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ws0_rd15_lat: got %0d expected 1", lat); end
        vectors++; if (q !== 32'hF0F0F0F0) begin miscompares++; $display("FAIL ws0_rd15: got %h expected f0f0f0f0", q); end
        xfer(1, 0, 8'd0, 32'h0, lat, q);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ws0_rd0_lat: got %0d expected 1", lat); end
        vectors++; if (q !== 32'h0A0A0A0A) begin miscompares++; $display("FAIL ws0_rd0: got %h expected 0a0a0a0a", q); end
        xfer(1, 1, 8'd15, 32'h12345678, lat, q);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL ws0_wr15_lat: got %0d expected 1", lat); end
        xfer(1, 0, 8'd0, 32'h0, lat, q);
        vectors++; if (q !== 32'h0A0A0A0A) begin miscompares++; $display("FAIL ws0_alias0: got %h expected 0a0a0a0a", q); end
        xfer(1, 0, 8'd15, 32'h0, lat, q);
        vectors++; if (q !== 32'h12345678) begin miscompares++; $display("FAIL ws0_rd15_new: got %h expected 12345678", q); end
    endtask

    task automatic test_back_to_back;
        b_as_n = 0; b_wr_n = 1; b_addr = 4'd0;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 20 && t2 < 0; i++) begin
            @(negedge clk);
            if (b_ack_n === 1'b0) begin
                if (t1 < 0) t1 = i; else t2 = i;
                b_as_n = 1;
            end else b_as_n = 0;
        end
        b_as_n = 1;
        vectors++; if (t1 !== 1) begin miscompares++; $display("FAIL b2b_first: got %0d expected 1", t1); end
        vectors++; if (t2 - t1 !== 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 3", t2 - t1); end
        vectors++; if (b_do !== 32'h0A0A0A0A) begin miscompares++; $display("FAIL b2b_data: got %h expected 0a0a0a0a", b_do); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_loader_read;
        test_write_read;
        test_hold;
        test_reset_mid;
        test_loader_drop;
        test_wrap;
        test_ws0;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
